// File: rtl/mod_arbiter.sv
// Round-robin front end sharing one modular-reduction engine between N_REQ requesters.
// Captures operands, sequences engine start/done, rejects mod==0 and aborts on engine hang.
`timescale 1ns/1ps
module mod_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  req_k,
  input  logic [8*N_REQ-1:0]   req_mod,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [7:0]           rsp_out,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 eng_start,
  output logic [15:0]          eng_k,
  output logic [7:0]           eng_mod,
  input  logic                 eng_done,
  input  logic [7:0]           eng_out
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state_r;
  logic [IW-1:0]     rr_ptr_r;
  logic [IW-1:0]     id_r;
  logic [TW-1:0]     timer_r;
  logic [N_REQ-1:0]  gnt_r;
  logic [N_REQ-1:0]  rsp_valid_r;
  logic [7:0]        rsp_out_r;
  logic              rsp_err_r;
  logic              busy_r;
  logic              eng_start_r;
  logic [15:0]       eng_k_r;
  logic [7:0]        eng_mod_r;

  logic [IW-1:0]     pick_id_s;
  logic              pick_vld_s;
  logic [15:0]       pick_k_s;
  logic [7:0]        pick_mod_s;

  function automatic logic [N_REQ-1:0] to_onehot(input logic [IW-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [IW-1:0] rot_idx(input logic [IW-1:0] base, input int off);
    return IW'((int'(base) + off) % N_REQ);
  endfunction

  // Round-robin pick: scanning from the highest offset down lets the offset closest to rr_ptr win.
  always_comb begin
    pick_vld_s = 1'b0;
    pick_id_s  = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      pick_id_s  = req[rot_idx(rr_ptr_r, j)] ? rot_idx(rr_ptr_r, j) : pick_id_s;
      pick_vld_s = pick_vld_s | req[rot_idx(rr_ptr_r, j)];
    end
  end

  // Operand mux for the selected requester.
  always_comb begin
    pick_k_s   = 16'd0;
    pick_mod_s = 8'd0;
    for (int j = 0; j < N_REQ; j++) begin
      pick_k_s   = (pick_id_s == IW'(j)) ? req_k[16*j +: 16] : pick_k_s;
      pick_mod_s = (pick_id_s == IW'(j)) ? req_mod[8*j +: 8] : pick_mod_s;
    end
  end

  // Transaction FSM; every output is a register so nothing combinational reaches gnt from req.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r     <= S_IDLE;
      rr_ptr_r    <= '0;
      id_r        <= '0;
      timer_r     <= '0;
      gnt_r       <= '0;
      rsp_valid_r <= '0;
      rsp_out_r   <= 8'd0;
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      eng_start_r <= 1'b0;
      eng_k_r     <= 16'd0;
      eng_mod_r   <= 8'd0;
    end else begin
      gnt_r       <= '0;
      rsp_valid_r <= '0;
      rsp_out_r   <= 8'd0;
      rsp_err_r   <= 1'b0;
      eng_start_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (pick_vld_s) begin
            id_r        <= pick_id_s;
            eng_k_r     <= pick_k_s;
            eng_mod_r   <= pick_mod_s;
            gnt_r       <= to_onehot(pick_id_s);
            eng_start_r <= (pick_mod_s != 8'd0);
            busy_r      <= 1'b1;
            state_r     <= S_ISSUE;
          end else begin
            state_r     <= S_IDLE;
          end
        end
        S_ISSUE: begin
          timer_r <= '0;
          if (eng_mod_r != 8'd0) begin
            state_r <= S_WAIT;
          end else begin
            rsp_valid_r <= to_onehot(id_r);
            rsp_err_r   <= 1'b1;
            state_r     <= S_RESP;
          end
        end
        S_WAIT: begin
          // A completion on the last allowed cycle still counts as success.
          if (eng_done) begin
            rsp_valid_r <= to_onehot(id_r);
            rsp_out_r   <= eng_out;
            state_r     <= S_RESP;
          end else if (timer_r == TW'(TIMEOUT - 1)) begin
            rsp_valid_r <= to_onehot(id_r);
            rsp_err_r   <= 1'b1;
            state_r     <= S_RESP;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        S_RESP: begin
          rr_ptr_r <= (id_r == IW'(N_REQ - 1)) ? '0 : id_r + IW'(1);
          busy_r   <= 1'b0;
          state_r  <= S_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_out   = rsp_out_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = busy_r;
  assign eng_start = eng_start_r;
  assign eng_k     = eng_k_r;
  assign eng_mod   = eng_mod_r;

endmodule
